countdown_alarm_timer: RTL and testbench
========================================

Name: countdown_alarm_timer

Overview:
- Loadable BCD countdown timer (MM:SS, 00:00 to 59:59) for the alarm-clock subsystem. It is the down-counting counterpart of the up-counting seconds/minutes counter.
- Counts down on a 1 Hz enable strobe and raises an alarm when it reaches 00:00.
- Single clock domain. All state advances on posedge clk; no derived clocks are used.

Parameters:
- ALARM_TICKS, default 10: number of tick strobes alarm stays asserted before auto-clear (range 1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- tick  input  1  one-cycle 1 Hz enable strobe from the prescaler.
- load  input  1  one-cycle strobe that captures the ld_* digits.
- ld_min_t  input  3  minutes tens, valid range 0..5.
- ld_min_o  input  4  minutes ones, valid range 0..9.
- ld_sec_t  input  3  seconds tens, valid range 0..5.
- ld_sec_o  input  4  seconds ones, valid range 0..9.
- start  input  1  one-cycle strobe: start or resume counting.
- pause  input  1  one-cycle strobe: pause counting, or acknowledge the alarm.
- min_t  output  3  current minutes tens.
- min_o  output  4  current minutes ones.
- sec_t  output  3  current seconds tens.
- sec_o  output  4  current seconds ones.
- running  output  1  high while in RUN.
- alarm  output  1  high while in ALARM.
- done  output  1  one-cycle pulse on the 00:00 transition.
- load_err  output  1  one-cycle pulse when a load carries an invalid digit.

Behaviour:
- Reset:
  - state=IDLE.
  - All digits 0.
  - running=0, alarm=0, done=0, load_err=0.
  - Alarm tick counter cleared.
- States: IDLE, RUN, PAUSED, ALARM. State is registered; all outputs are registered.
- Event priority within a cycle: rst > load > pause > start > tick.
- load:
  - Accepted in IDLE, PAUSED and ALARM. Captured digits appear on the outputs the next cycle.
  - Next state is IDLE, which also clears alarm.
  - If any digit is out of range: digits are unchanged, load_err pulses for 1 cycle, and the state is unchanged.
  - In RUN, load is ignored.
- start:
  - IDLE or PAUSED with value != 00:00: go to RUN.
  - Value == 00:00: start is ignored.
  - In RUN or ALARM, start has no effect.
- pause:
  - RUN: go to PAUSED.
  - ALARM: go to IDLE (acknowledge); digits stay at 00:00.
  - Otherwise ignored.
- tick in RUN (with no higher-priority event) decrements by one second:
  - sec_o>0: sec_o-1.
  - sec_o=0: sec_o=9, then borrow into sec_t.
  - sec_t=0 on borrow: sec_t=5, then borrow into min_o.
  - min_o=0 on borrow: min_o=9, then borrow into min_t.
  - All digits update on the same edge.
- Reaching zero:
  - If the decremented result is 00:00: on the same edge state becomes ALARM, done pulses the next cycle for exactly 1 cycle, and the alarm counter resets to 0.
  - No decrement ever occurs below 00:00.
- Ticks outside RUN have no effect on the digits. A tick in the same cycle as pause in RUN is dropped (no decrement).
- ALARM:
  - Each tick increments the alarm counter.
  - When the counter reaches ALARM_TICKS: state=IDLE, alarm deasserts.
  - Alarm therefore stays high for ALARM_TICKS ticks unless pause or load ends it earlier.
- Combined outputs: running=(state==RUN); alarm=(state==ALARM).
- rst mid-count returns to reset values on the next edge regardless of state.

Decomposition:
- Package timer_pkg:
  - State enum (IDLE, RUN, PAUSED, ALARM).
  - Constants: SEC_T_MAX=5, MIN_T_MAX=5, ONES_MAX=9.
  - Digit width constants.
- Sub-module bcd_digit_down:
  - Parameter MAX.
  - Inputs: clk, rst, ld, ld_val, dec_en, borrow_in.
  - Outputs: val, zero, borrow_out (asserted when val==0 and the digit is decremented).
  - Instantiated 4 times, chained by borrow. Top-level FSM, validation and alarm counter: about 200 lines.

Test Plan:
- Load 00:03, start, 3 ticks: values 00:02, 00:01, 00:00; on the third tick state=ALARM, done pulses once, alarm=1.
- Load 10:00, start, 1 tick: value 09:59 (full borrow chain).
- Load 00:05, start, 2 ticks, pause asserted with a tick in the same cycle: value holds 00:04 (no decrement); further ticks ignored; start then 1 tick gives 00:03.
- ALARM_TICKS=3: reach 00:00, then 3 ticks → alarm falls and state=IDLE. Repeat with pause on the first alarm cycle → immediate IDLE.
- Load with ld_sec_t=6 → load_err pulses 1 cycle, digits unchanged. Load 00:00 then start → stays IDLE, running=0.
- Running at 12:34, assert rst 1 cycle → all digits 0, running=0, alarm=0 on the next edge. Load during RUN is ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown alarm timer.
//   state_e      : control FSM states (IDLE, RUN, PAUSED, ALARM)
//   *_MAX        : largest legal value of each BCD digit position
//   *_W          : bit widths of the tens / ones digits and the alarm counter
//   digits_valid : true when a set of load digits forms a legal MM:SS value
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        ALARM  = 2'd3
    } state_e;

    localparam int SEC_T_MAX = 5;
    localparam int MIN_T_MAX = 5;
    localparam int ONES_MAX  = 9;

    localparam int TENS_W = 3;
    localparam int ONES_W = 4;
    localparam int ACNT_W = 8;

    function automatic logic digits_valid(
        input logic [TENS_W-1:0] min_t,
        input logic [ONES_W-1:0] min_o,
        input logic [TENS_W-1:0] sec_t,
        input logic [ONES_W-1:0] sec_o
    );
        return (min_t <= TENS_W'(MIN_T_MAX)) &&
               (min_o <= ONES_W'(ONES_MAX))  &&
               (sec_t <= TENS_W'(SEC_T_MAX)) &&
               (sec_o <= ONES_W'(ONES_MAX));
    endfunction

endpackage

// File: rtl/countdown_alarm_timer_if.sv
// Control and display bundle of the countdown alarm timer.
//   master : strobe/load source (prescaler, buttons), sees the display
//   slave  : the timer; consumes strobes and load digits, drives the
//            MM:SS digits and the running/alarm/done/load_err flags
interface countdown_alarm_timer_if;
    import timer_pkg::*;

    logic              tick;
    logic              load;
    logic [TENS_W-1:0] ld_min_t;
    logic [ONES_W-1:0] ld_min_o;
    logic [TENS_W-1:0] ld_sec_t;
    logic [ONES_W-1:0] ld_sec_o;
    logic              start;
    logic              pause;

    logic [TENS_W-1:0] min_t;
    logic [ONES_W-1:0] min_o;
    logic [TENS_W-1:0] sec_t;
    logic [ONES_W-1:0] sec_o;
    logic              running;
    logic              alarm;
    logic              done;
    logic              load_err;

    modport master (
        output tick, load, ld_min_t, ld_min_o, ld_sec_t, ld_sec_o, start, pause,
        input  min_t, min_o, sec_t, sec_o, running, alarm, done, load_err
    );

    modport slave (
        input  tick, load, ld_min_t, ld_min_o, ld_sec_t, ld_sec_o, start, pause,
        output min_t, min_o, sec_t, sec_o, running, alarm, done, load_err
    );

endinterface

// File: rtl/bcd_digit_down.sv
// One loadable down-counting BCD digit with borrow chaining.
//   clk, rst   : clock, synchronous active-high reset (digit -> 0)
//   ld, ld_val : load the digit (has priority over decrement)
//   dec_en     : decrement permitted this cycle
//   borrow_in  : the lower digit wrapped (tie high on the least significant digit)
//   val        : current digit value
//   zero       : val == 0
//   borrow_out : this digit is decremented while at 0 and wraps to MAX
module bcd_digit_down #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         dec_en,
    input  logic         borrow_in,
    output logic [W-1:0] val,
    output logic         zero,
    output logic         borrow_out
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;
    logic         step;

    assign step = dec_en && borrow_in;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        val_d = val_q;
        if (ld) begin
            val_d = ld_val;
        end else if (step) begin
            val_d = (val_q == '0) ? W'(MAX) : val_q - W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val        = val_q;
    assign zero       = (val_q == '0);
    assign borrow_out = step && zero;

endmodule

// File: rtl/countdown_alarm_timer.sv
// Loadable BCD MM:SS countdown timer with alarm.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : tick/load/start/pause strobes and ld_* digits in;
//                 min_t/min_o/sec_t/sec_o digits, running, alarm,
//                 done (1-cycle pulse on reaching 00:00) and load_err
//                 (1-cycle pulse on an out-of-range load) out.
// Event priority in a cycle: rst > load > pause > start > tick.
// The alarm stays up for ALARM_TICKS ticks unless pause or load ends it.
module countdown_alarm_timer
    import timer_pkg::*;
#(
    parameter int ALARM_TICKS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    countdown_alarm_timer_if.slave  bus
);

    logic              ld_digits;
    logic              dec_en;

    logic [TENS_W-1:0] min_t_val;
    logic [ONES_W-1:0] min_o_val;
    logic [TENS_W-1:0] sec_t_val;
    logic [ONES_W-1:0] sec_o_val;
    logic              mt_zero, mo_zero, st_zero, so_zero;
    logic              mo_borrow, st_borrow, so_borrow, mt_borrow;

    state_e            state_q, state_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;
    logic              done_q, done_d;
    logic              load_err_q, load_err_d;
    logic              running_q, running_d;
    logic              alarm_q, alarm_d;

    logic              ld_ok;
    logic              is_zero;
    logic              at_one;

    assign ld_ok   = digits_valid(bus.ld_min_t, bus.ld_min_o, bus.ld_sec_t, bus.ld_sec_o);
    assign is_zero = mt_zero && mo_zero && st_zero && so_zero;
    // 00:01 is the only value whose decrement lands on 00:00.
    assign at_one  = mt_zero && mo_zero && st_zero && (sec_o_val == ONES_W'(1));

    // Seconds-ones is the least significant digit, so it always sees a borrow.
    bcd_digit_down #(.MAX(ONES_MAX), .W(ONES_W)) u_sec_o (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld_digits),
        .ld_val     (bus.ld_sec_o),
        .dec_en     (dec_en),
        .borrow_in  (1'b1),
        .val        (sec_o_val),
        .zero       (so_zero),
        .borrow_out (so_borrow)
    );

    bcd_digit_down #(.MAX(SEC_T_MAX), .W(TENS_W)) u_sec_t (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld_digits),
        .ld_val     (bus.ld_sec_t),
        .dec_en     (dec_en),
        .borrow_in  (so_borrow),
        .val        (sec_t_val),
        .zero       (st_zero),
        .borrow_out (st_borrow)
    );

    bcd_digit_down #(.MAX(ONES_MAX), .W(ONES_W)) u_min_o (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld_digits),
        .ld_val     (bus.ld_min_o),
        .dec_en     (dec_en),
        .borrow_in  (st_borrow),
        .val        (min_o_val),
        .zero       (mo_zero),
        .borrow_out (mo_borrow)
    );

    bcd_digit_down #(.MAX(MIN_T_MAX), .W(TENS_W)) u_min_t (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld_digits),
        .ld_val     (bus.ld_min_t),
        .dec_en     (dec_en),
        .borrow_in  (mo_borrow),
        .val        (min_t_val),
        .zero       (mt_zero),
        .borrow_out (mt_borrow)
    );

    // The FSM stops at 00:00, so the top digit must never wrap below zero.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !mt_borrow);

    always_comb begin
        state_d    = state_q;
        acnt_d     = acnt_q;
        ld_digits  = 1'b0;
        dec_en     = 1'b0;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        unique case (state_q)
            IDLE, PAUSED: begin
                if (bus.load) begin
                    if (ld_ok) begin
                        ld_digits = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (bus.start && !is_zero) begin
                    state_d = RUN;
                end
            end

            // load is ignored while counting; a tick alongside pause is dropped.
            RUN: begin
                if (bus.pause) begin
                    state_d = PAUSED;
                end else if (bus.tick) begin
                    dec_en = 1'b1;
                    if (at_one) begin
                        state_d = ALARM;
                        done_d  = 1'b1;
                        acnt_d  = '0;
                    end
                end
            end

            ALARM: begin
                if (bus.load) begin
                    if (ld_ok) begin
                        ld_digits = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (bus.pause) begin
                    state_d = IDLE;
                end else if (bus.tick) begin
                    acnt_d = acnt_q + ACNT_W'(1);
                    if (acnt_d == ACNT_W'(ALARM_TICKS)) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Flags are decoded from the next state so they are registered
        // alongside the state rather than decoded after the flop.
        running_d = (state_d == RUN);
        alarm_d   = (state_d == ALARM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acnt_q     <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acnt_q     <= acnt_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
            running_q  <= running_d;
            alarm_q    <= alarm_d;
        end
    end

    assign bus.min_t    = min_t_val;
    assign bus.min_o    = min_o_val;
    assign bus.sec_t    = sec_t_val;
    assign bus.sec_o    = sec_o_val;
    assign bus.running  = running_q;
    assign bus.alarm    = alarm_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_countdown_alarm_timer.sv
// Scoreboard bench for countdown_alarm_timer. The driver applies one
// cycle of stimulus at each falling edge, advances a reference model that
// keeps the timer value as plain seconds, and queues the expected outputs
// for the following rising edge; the monitor compares them just after it.
module tb_countdown_alarm_timer;

    localparam int AT = 3;

    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_ALARM} mstate_t;

    typedef struct packed {
        logic [13:0] digits;
        logic        running;
        logic        alarm;
        logic        done;
        logic        load_err;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    countdown_alarm_timer_if bus ();

    countdown_alarm_timer #(.ALARM_TICKS(AT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t    exp_q[$];
    int      checks   = 0;
    int      failures = 0;
    bit      stim_done = 1'b0;

    int      m_secs = 0;
    int      m_acnt = 0;
    mstate_t m_st   = M_IDLE;

    function automatic obs_t expected(input bit done, input bit err);
        obs_t o;
        o.digits   = {3'(m_secs / 600), 4'((m_secs / 60) % 10),
                      3'((m_secs % 60) / 10), 4'(m_secs % 10)};
        o.running  = (m_st == M_RUN);
        o.alarm    = (m_st == M_ALARM);
        o.done     = done;
        o.load_err = err;
        return o;
    endfunction

    task automatic drive(input bit r, input bit ld, input int mt, input int mo,
                         input int st, input int so, input bit sta,
                         input bit pa, input bit tk);
        bit m_done = 1'b0;
        bit m_err  = 1'b0;
        @(negedge clk);
        rst          = r;
        bus.load     = ld;
        bus.ld_min_t = 3'(mt);
        bus.ld_min_o = 4'(mo);
        bus.ld_sec_t = 3'(st);
        bus.ld_sec_o = 4'(so);
        bus.start    = sta;
        bus.pause    = pa;
        bus.tick     = tk;

        if (r) begin
            m_secs = 0;
            m_st   = M_IDLE;
            m_acnt = 0;
        end else if (ld && m_st != M_RUN) begin
            if (mt <= 5 && mo <= 9 && st <= 5 && so <= 9) begin
                m_secs = mt * 600 + mo * 60 + st * 10 + so;
                m_st   = M_IDLE;
            end else begin
                m_err = 1'b1;
            end
        end else if (pa && m_st == M_RUN) begin
            m_st = M_PAUSED;
        end else if (pa && m_st == M_ALARM) begin
            m_st = M_IDLE;
        end else if (sta && (m_st == M_IDLE || m_st == M_PAUSED) && m_secs != 0) begin
            m_st = M_RUN;
        end else if (tk && m_st == M_RUN) begin
            m_secs--;
            if (m_secs == 0) begin
                m_st   = M_ALARM;
                m_done = 1'b1;
                m_acnt = 0;
            end
        end else if (tk && m_st == M_ALARM) begin
            m_acnt++;
            if (m_acnt == AT) m_st = M_IDLE;
        end

        exp_q.push_back(expected(m_done, m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_load(input int mt, input int mo, input int st, input int so);
        drive(0, 1, mt, mo, st, so, 0, 0, 0);
    endtask
    task automatic do_start();      drive(0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_pause();      drive(0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic do_tick();       drive(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic do_pause_tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); endtask
    task automatic do_rst();        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a full set of registered outputs every cycle.
    initial begin
        obs_t e;
        obs_t a;
        while (!stim_done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.digits   = {bus.min_t, bus.min_o, bus.sec_t, bus.sec_o};
                a.running  = bus.running;
                a.alarm    = bus.alarm;
                a.done     = bus.done;
                a.load_err = bus.load_err;
                check("digits", {2'b00, a.digits}, {2'b00, e.digits});
                check("flags run/alarm/done/err",
                      {12'h000, a.running, a.alarm, a.done, a.load_err},
                      {12'h000, e.running, e.alarm, e.done, e.load_err});
            end
        end
    end

    initial begin
        bus.tick = 0; bus.load = 0; bus.start = 0; bus.pause = 0;
        bus.ld_min_t = 0; bus.ld_min_o = 0; bus.ld_sec_t = 0; bus.ld_sec_o = 0;

        do_rst(); do_rst();

        // 00:03 down to zero, then the alarm times out after AT ticks.
        do_load(0, 0, 0, 3); do_start();
        do_tick(); do_tick(); do_tick(); idle(2);
        do_tick(); idle(1); do_tick(); do_tick(); idle(2);

        // Full borrow chain 10:00 -> 09:59.
        do_load(1, 0, 0, 0); do_start(); do_tick(); idle(1); do_pause();

        // Tick coinciding with pause is dropped; ticks while paused ignored.
        do_load(0, 0, 0, 5); do_start(); do_tick(); do_pause_tick();
        do_tick(); do_tick(); do_start(); do_tick(); do_pause();

        // Alarm acknowledged on its first cycle.
        do_load(0, 0, 0, 1); do_start(); do_tick(); do_pause(); idle(1);

        // Invalid load digits, then start on 00:00 is ignored.
        do_load(0, 2, 0, 0); do_load(0, 0, 6, 0); idle(1); do_load(6, 0, 0, 0);
        do_load(0, 0, 0, 12);
        do_load(0, 0, 0, 0); do_start(); idle(1);

        // Load ignored in RUN, then synchronous reset mid-count.
        do_load(1, 2, 3, 4); do_start(); do_tick();
        do_load(5, 5, 5, 5); do_tick(); do_rst(); idle(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, ld, sta, pa, tk;
            int v, mt, mo, st, so;
            r   = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 14) == 0);
            sta = ($urandom_range(0, 5) == 0);
            pa  = ($urandom_range(0, 11) == 0);
            tk  = ($urandom_range(0, 1) == 0);
            v   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3599))
                                              : int'($urandom_range(0, 20));
            mt = v / 600; mo = (v / 60) % 10; st = (v % 60) / 10; so = v % 10;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: mt = int'($urandom_range(6, 7));
                    1: mo = int'($urandom_range(10, 15));
                    2: st = int'($urandom_range(6, 7));
                    default: so = int'($urandom_range(10, 15));
                endcase
            end
            drive(r, ld, mt, mo, st, so, sta, pa, tk);
        end

        idle(2);
        @(negedge clk);
        stim_done = 1'b1;
        check("scoreboard drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
